stream_demux1x2: RTL and testbench

Packet-aware 1-to-2 stream demultiplexer: the routing counterpart of the 2:1 gate-level mux. One valid/ready input stream is steered to output channel 0 or 1 by select `s`, sampled on a packet's first beat and locked until its last beat. Each output has a 2-entry skid buffer for full throughput and a wrapping count of delivered packets. Sits between a single producer and two independent consumers.

---
 rtl/stream_demux_pkg.sv | 7 +
 rtl/demux_skid_buf.sv | 30 +++
 rtl/stream_demux1x2.sv | 70 +++++++
 tb/tb_stream_demux1x2.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared FSM encoding and skid-buffer depth for the 1-to-2 stream demux
package stream_demux_pkg;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ROUTE0    = 2'd1;
    localparam logic [1:0] ROUTE1    = 2'd2;
    localparam logic [1:0] BUF_DEPTH = 2'd2;
endpackage

// File: rtl/demux_skid_buf.sv
// demux_skid_buf: 2-entry FIFO whose head entry is always presented on the output
module demux_skid_buf
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem1;

    // head slot refills from input when it would otherwise go empty, else shifts up from slot 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= din;
            else if (pop && count == BUF_DEPTH) head <= mem1;
            if (push && ((count == 2'd1 && !pop) || count == BUF_DEPTH)) mem1 <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/stream_demux1x2.sv
// stream_demux1x2: packet-locked 1-to-2 valid/ready demux with per-output skid buffers and packet counters
module stream_demux1x2
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic             s,
    output logic             i_ready,
    output logic [WIDTH-1:0] y0_data,
    output logic [WIDTH-1:0] y1_data,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y0_last,
    output logic             y1_last,
    input  logic             y0_ready,
    input  logic             y1_ready,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);
    logic [1:0]     state;
    logic [1:0]     cnt0, cnt1;
    logic [WIDTH:0] head0, head1;
    logic           tgt, acc, pop0, pop1;

    // select is only honoured at a packet start; mid-packet the route is locked by the state
    assign tgt      = (state == ROUTE1) || (state == IDLE && s);
    assign i_ready  = !rst && ((tgt ? cnt1 : cnt0) < BUF_DEPTH);
    assign acc      = i_valid && i_ready;
    assign y0_valid = cnt0 != 2'd0;
    assign y1_valid = cnt1 != 2'd0;
    assign pop0     = y0_valid && y0_ready;
    assign pop1     = y1_valid && y1_ready;
    assign {y0_last, y0_data} = head0;
    assign {y1_last, y1_data} = head1;
    assign busy     = state != IDLE;

    // lock onto the chosen output after a non-final beat, release on the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (acc) state <= i_last ? IDLE : (tgt ? ROUTE1 : ROUTE0);
    end

    // count packets as their last beat leaves each output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (pop0 && y0_last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (pop1 && y1_last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
    end

    demux_skid_buf #(.WIDTH(WIDTH + 1)) u_buf0 (
        .clk(clk), .rst(rst), .push(acc && !tgt), .pop(pop0),
        .din({i_last, i_data}), .head(head0), .count(cnt0)
    );

    demux_skid_buf #(.WIDTH(WIDTH + 1)) u_buf1 (
        .clk(clk), .rst(rst), .push(acc && tgt), .pop(pop1),
        .din({i_last, i_data}), .head(head1), .count(cnt1)
    );
endmodule

// File: tb/tb_stream_demux1x2.sv
// tb_stream_demux1x2: directed and random checks of the demux against a queue-based reference model
module tb_stream_demux1x2;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 0, rst = 0;
    logic [W-1:0]  i_data = 0;
    logic          i_valid = 0, i_last = 0, s = 0;
    logic          i_ready;
    logic [W-1:0]  y0_data, y1_data;
    logic          y0_valid, y1_valid, y0_last, y1_last;
    logic          y0_ready = 1, y1_ready = 1;
    logic          busy;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    stream_demux1x2 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .s(s),
        .i_ready(i_ready), .y0_data(y0_data), .y1_data(y1_data), .y0_valid(y0_valid),
        .y1_valid(y1_valid), .y0_last(y0_last), .y1_last(y1_last), .y0_ready(y0_ready),
        .y1_ready(y1_ready), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    int         n_pass = 0, n_tot = 0;
    logic [W:0] q0[$], q1[$];
    int         e_cnt0 = 0, e_cnt1 = 0;
    bit         m_busy = 0, m_tgt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one clock: check outputs at negedge against the model, then advance the model at posedge
    task automatic cycle(output bit acc);
        bit         tgt, rdy, p0, p1;
        logic [W:0] b;
        @(negedge clk);
        tgt = m_busy ? m_tgt : s;
        rdy = (tgt ? q1.size() : q0.size()) < 2;
        chk("i_ready", i_ready, rdy);
        chk("busy", busy, m_busy);
        chk("y0_valid", y0_valid, q0.size() != 0);
        chk("y1_valid", y1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("y0_beat", {y0_last, y0_data}, q0[0]);
        if (q1.size() != 0) chk("y1_beat", {y1_last, y1_data}, q1[0]);
        chk("pkt_cnt0", pkt_cnt0, e_cnt0 % (1 << CW));
        chk("pkt_cnt1", pkt_cnt1, e_cnt1 % (1 << CW));
        acc = i_valid && rdy;
        b   = {i_last, i_data};
        p0  = q0.size() != 0 && y0_ready;
        p1  = q1.size() != 0 && y1_ready;
        @(posedge clk);
        if (p0) begin
            if (q0[0][W]) e_cnt0++;
            void'(q0.pop_front());
        end
        if (p1) begin
            if (q1[0][W]) e_cnt1++;
            void'(q1.pop_front());
        end
        if (acc) begin
            if (tgt) q1.push_back(b);
            else q0.push_back(b);
            m_busy = !b[W];
            m_tgt  = tgt;
        end
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit l, input bit sel);
        bit a = 0;
        i_valid = 1; i_data = d; i_last = l; s = sel;
        for (int k = 0; k < 40 && !a; k++) cycle(a);
        chk("send_timeout", a, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        i_valid = 0;
        for (int k = 0; k < n; k++) cycle(a);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_y0_valid", y0_valid, 0);
        chk("rst_y1_valid", y1_valid, 0);
        chk("rst_y0_beat", {y0_last, y0_data}, 0);
        chk("rst_y1_beat", {y1_last, y1_data}, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_i_ready", i_ready, 0);
        q0.delete(); q1.delete();
        e_cnt0 = 0; e_cnt1 = 0; m_busy = 0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        bit a = 0;
        #2;
        do_reset();
        send(8'h11, 1, 0); send(8'h22, 1, 1); send(8'h33, 1, 0);
        idle(3);
        chk("single_cnt0", pkt_cnt0, 2);
        chk("single_cnt1", pkt_cnt1, 1);
        send(8'hA0, 0, 1); send(8'hA1, 0, 0); send(8'hA2, 0, 1); send(8'hA3, 1, 0);
        idle(3);
        chk("lock_cnt1", pkt_cnt1, 2);
        chk("lock_cnt0", pkt_cnt0, 2);
        y0_ready = 0;
        send(8'hB0, 0, 0); send(8'hB1, 0, 0);
        i_valid = 1; i_data = 8'hB2; i_last = 0; s = 0;
        for (int k = 0; k < 3; k++) cycle(a);
        chk("stall_ready", i_ready, 0);
        y0_ready = 1;
        send(8'hB2, 0, 0); send(8'hB3, 0, 0); send(8'hB4, 1, 0);
        idle(4);
        chk("stall_cnt0", pkt_cnt0, 3);
        y1_ready = 0;
        send(8'hC0, 0, 1); send(8'hC1, 1, 1);
        send(8'hD0, 0, 0); send(8'hD1, 0, 0); send(8'hD2, 1, 0);
        idle(2);
        chk("indep_y1_head", {y1_valid, y1_last, y1_data}, {2'b10, 8'hC0});
        chk("indep_cnt0", pkt_cnt0, 4);
        y1_ready = 1;
        idle(3);
        y0_ready = 0;
        send(8'h55, 0, 0);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        y0_ready = 1;
        send(8'h66, 1, 1);
        idle(2);
        chk("post_rst_cnt1", pkt_cnt1, 1);
        chk("post_rst_cnt0", pkt_cnt0, 0);
        for (int k = 0; k < 256; k++) send(8'(k), 1, 0);
        idle(3);
        chk("wrap_cnt0", pkt_cnt0, 0);
        a = 1;
        i_valid = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!i_valid || a) begin
                i_valid = $urandom_range(0, 3) != 0;
                i_data  = 8'($urandom);
                i_last  = $urandom_range(0, 2) == 0;
                s       = 1'($urandom);
            end
            y0_ready = $urandom_range(0, 3) != 0;
            y1_ready = $urandom_range(0, 3) != 0;
            cycle(a);
        end
        y0_ready = 1; y1_ready = 1;
        idle(10);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
